pipe_adder_hs: RTL

PIPE_ADDER_HS -- requirements
Module: pipe_adder_hs

---
 rtl/pipe_adder_hs.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_adder_hs.sv
// rtl/pipe_adder_hs.sv - segmented carry-pipelined adder/subtractor with valid/ready handshake
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder_hs #(
    parameter int WIDTH = 128,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];

    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [SEG:0]      seg_sum [STAGES];
    logic              advance;

    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;
    assign out_valid = v_r[LAST];
    assign s         = s_r[LAST];
    assign cout      = c_r[LAST];

    // B is stored pre-inverted for subtraction, so the mode travels implicitly with each operation.
    always_comb begin
        v_src    = '0;
        c_src    = '0;
        c_nxt    = '0;
        v_src[0] = in_valid;
        c_src[0] = sub | cin;
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_r[k-1];
            c_src[k] = c_r[k-1];
            a_src[k] = a_r[k-1];
            b_src[k] = b_r[k-1];
            s_src[k] = s_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            c_nxt[k] = seg_sum[k][SEG];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= '0;
            c_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else if (advance) begin
            v_r <= v_src;
            c_r <= c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= a_src[k];
                b_r[k] <= b_src[k];
                s_r[k] <= s_nxt[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_r;
    logic ovf_nxt;

    // Operand signs agree but the result sign differs: signed overflow.
    assign ovf_nxt = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1])
                  && (s_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
    assign ovf     = ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance) begin
            ovf_r <= ovf_nxt;
        end
    end
`endif

endmodule
